fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Instruction fetch front-end between the instruction ROM and the control/decode stage. It starts on a req pulse and walks the program counter from 0. It prefetches ROM words into a small queue tagged with their PC, and hands them to decode over a valid/ready handshake. It flushes and redirects on an absolute jump, and raises done once the end-of-program marker has been reached and the queue has drained.

Parameters:
PC_W, 12, program counter / ROM address width
INSTR_W, 9, machine code width
DEPTH, 4, prefetch queue entries (power of 2, >=2)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
req  in  1  start request, sampled in IDLE/DONE only
rom_addr  out  PC_W  address to instruction ROM (combinational read, data valid same cycle)
rom_data  in  INSTR_W  ROM word at rom_addr
rom_end  in  1  ROM flags rom_addr as past end of program
jump_en  in  1  redirect request from control/ALU branch resolution
jump_target  in  PC_W  absolute redirect address
instr  out  INSTR_W  head-of-queue machine code
instr_pc  out  PC_W  PC of head entry
instr_valid  out  1  head entry present
instr_ready  in  1  decode accepts head this cycle
busy  out  1  state is RUN or DRAIN
done  out  1  program complete, held until next req

Behaviour:
- Reset (reset=0, async): state=IDLE, fetch_pc=0, queue empty; rom_addr=0, instr=0, instr_pc=0, instr_valid=0, busy=0, done=0.
- rom_addr = fetch_pc at all times; instr/instr_pc are 0 when the queue is empty.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: req=1 -> RUN, fetch_pc=0.
  - RUN, per edge:
    - push = !rom_end && (count<DEPTH || pop); on push, enqueue {fetch_pc, rom_data} and fetch_pc++.
    - rom_end=1 -> DRAIN, fetch_pc holds, no push.
  - DRAIN: no pushes. Queue empty (after this edge's pop) -> DONE.
  - DONE: done=1. req=1 -> RUN, fetch_pc=0, done=0 next cycle.
  - req in RUN/DRAIN is ignored.
- pop = instr_valid && instr_ready; the head is removed at the edge.
- jump_en=1 in RUN or DRAIN, at the edge:
  - queue flushed (count=0); the same-edge push is dropped; the same-edge pop is irrelevant.
  - fetch_pc=jump_target; state=RUN.
  - Jump has priority over rom_end, push and the DRAIN->DONE transition.
  - jump_en in IDLE/DONE is ignored.
- Latency: req sampled at edge E0; rom_addr=0 in the following cycle; the entry is pushed at E1; instr_valid=1 after E1. After a jump at edge J, the target entry is valid after J+1 (1-cycle bubble).
- Throughput: 1 instr/cycle when instr_ready is held high.
- Full with pop: push and pop on the same edge, count unchanged.
- Empty with push: no same-cycle bypass; valid next cycle.
- fetch_pc wraps modulo 2^PC_W (4095 -> 0) with no error.
- Async reset mid-operation discards all queue contents and state immediately.
- Queue count width: clog2(DEPTH)+1; pointers wrap modulo DEPTH.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {IDLE, RUN, DRAIN, DONE}
  - fetch_entry_t struct {pc[PC_W], instr[INSTR_W]}
  - defaults PC_W=12, INSTR_W=9
- Sub-module fetch_fifo:
  - synchronous FIFO of fetch_entry_t, DEPTH entries
  - push/pop/flush inputs (flush highest priority); full/empty/count outputs
  - same async active-low reset
- fetch_queue holds the FSM, fetch_pc and the push/jump arbitration.

Test Plan:
- Reset, then req pulse, ROM words 0x101,0x002,0x1FF at 0..2, rom_end at 3, instr_ready=1 -> instr_valid from 2nd cycle after req; instr/instr_pc sequence 0x101/0, 0x002/1, 0x1FF/2; done=1 one cycle after last pop; busy low.
- instr_ready=0 for 10 cycles after start -> count saturates at DEPTH=4, fetch_pc stops at 4 (rom_addr=4). Ready high -> pushes resume with no entry lost or duplicated; PCs stay contiguous.
- Jump while the queue holds PCs 5..8: pop PC 5 with jump_en=1, jump_target=0x020 -> next cycle instr_valid=0; following cycle instr_pc=0x020; PCs 6..8 never appear.
- Jump and rom_end on the same edge -> state RUN, fetch_pc=jump_target, no DONE. Jump in DRAIN with a non-empty queue -> back to RUN. jump_en in DONE -> ignored, done stays 1.
- Start fetch_pc near 0xFFE via jump, rom_end low -> instr_pc 0xFFE, 0xFFF, 0x000.
- Assert reset low mid-RUN with 3 entries queued -> all outputs 0 immediately (asynchronous). After release, req restarts from PC 0. req during RUN has no effect on the PC sequence.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, FSM state and queue entry types for the fetch front-end
package fetch_pkg;
  localparam int PC_W    = 12;
  localparam int INSTR_W = 9;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fetch_state_t;
  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry prefetch queue of PC-tagged ROM words
// Ports: clk/rst_n (async active-low), i_push/i_pop/i_flush (flush wins),
// i_data in, o_data head, o_full/o_empty/o_count status.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  fetch_entry_t               i_data,
  output fetch_entry_t               o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t    r_mem [DEPTH];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [AW:0]     r_count;
  logic            w_push;
  logic            w_pop;
  assign o_full  = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd];
  assign w_pop   = i_pop && !o_empty && !i_flush;
  // a pop on a full queue frees the slot the same edge, so the push may proceed
  assign w_push  = i_push && (!o_full || w_pop) && !i_flush;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front-end, prefetches ROM words and hands them to decode
// Ports: clk/rst_n (async active-low), i_req start pulse, o_rom_addr/i_rom_data/i_rom_end
// ROM side, i_jump_en/i_jump_target redirect, o_instr/o_instr_pc/o_instr_valid/i_instr_ready
// decode handshake, o_busy (RUN or DRAIN), o_done (program complete, held until next req).
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_req,
  output logic [PC_W-1:0]    o_rom_addr,
  input  logic [INSTR_W-1:0] i_rom_data,
  input  logic               i_rom_end,
  input  logic               i_jump_en,
  input  logic [PC_W-1:0]    i_jump_target,
  output logic [INSTR_W-1:0] o_instr,
  output logic [PC_W-1:0]    o_instr_pc,
  output logic               o_instr_valid,
  input  logic               i_instr_ready,
  output logic               o_busy,
  output logic               o_done
);
  fetch_state_t           r_state;
  fetch_state_t           w_next;
  logic [PC_W-1:0]        r_pc;
  logic [PC_W-1:0]        w_next_pc;
  fetch_entry_t           w_head;
  logic                   w_full;
  logic                   w_empty;
  logic [$clog2(DEPTH):0] w_count;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_jump;
  logic                   w_drained;
  assign w_jump    = i_jump_en && (r_state == RUN || r_state == DRAIN);
  assign w_pop     = !w_empty && i_instr_ready;
  assign w_push    = r_state == RUN && !i_rom_end && !w_jump && (!w_full || w_pop);
  // queue is empty once this edge's pop (if any) has been taken
  assign w_drained = w_empty || (w_count == 1 && w_pop);
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_jump),
    .i_data  ('{pc: r_pc, instr: i_rom_data}),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );
  always_comb begin
    w_next    = r_state;
    w_next_pc = r_pc;
    case (r_state)
      IDLE, DONE: if (i_req) begin
        w_next    = RUN;
        w_next_pc = '0;
      end
      RUN: if (i_rom_end) w_next = DRAIN;
           else if (w_push) w_next_pc = r_pc + 1'b1;
      DRAIN: if (w_drained) w_next = DONE;
      default: w_next = IDLE;
    endcase
    // redirect overrides end-of-program, the push and the drain completion
    if (w_jump) begin
      w_next    = RUN;
      w_next_pc = i_jump_target;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= '0;
    end else begin
      r_state <= w_next;
      r_pc    <= w_next_pc;
    end
  end
  assign o_rom_addr    = r_pc;
  assign o_instr_valid = !w_empty;
  assign o_instr       = w_empty ? '0 : w_head.instr;
  assign o_instr_pc    = w_empty ? '0 : w_head.pc;
  assign o_busy        = r_state == RUN || r_state == DRAIN;
  assign o_done        = r_state == DONE;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus with a queue-level reference model for fetch_queue
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_DONE = 3;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        req = 0;
  logic        jump_en = 0;
  logic [11:0] jump_target = 0;
  logic        ready = 0;
  logic [11:0] rom_addr;
  logic [8:0]  rom_data;
  logic        rom_end;
  logic [8:0]  instr;
  logic [11:0] instr_pc;
  logic        valid;
  logic        busy;
  logic        done;
  logic [8:0]  rom [4096];
  int          prog_end = 3;
  int          total = 0;
  int          bad = 0;
  int          ms = M_IDLE;
  int          mpc = 0;
  int          qpc[$];
  int          qins[$];
  int          popped[$];
  assign rom_data = rom[rom_addr];
  assign rom_end  = int'(rom_addr) >= prog_end;
  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_req         (req),
    .o_rom_addr    (rom_addr),
    .i_rom_data    (rom_data),
    .i_rom_end     (rom_end),
    .i_jump_en     (jump_en),
    .i_jump_target (jump_target),
    .o_instr       (instr),
    .o_instr_pc    (instr_pc),
    .o_instr_valid (valid),
    .i_instr_ready (ready),
    .o_busy        (busy),
    .o_done        (done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // reference: a queue of (pc, word) pairs advanced once per rising edge
  always @(posedge clk or negedge rst_n) begin
    int  n;
    bit  pop;
    if (!rst_n) begin
      ms = M_IDLE;
      mpc = 0;
      qpc.delete();
      qins.delete();
    end else if (ms == M_IDLE || ms == M_DONE) begin
      if (req) begin
        ms = M_RUN;
        mpc = 0;
      end
    end else begin
      n = qpc.size();
      pop = n > 0 && ready;
      if (jump_en) begin
        qpc.delete();
        qins.delete();
        mpc = jump_target;
        ms = M_RUN;
      end else begin
        if (pop) begin
          popped.push_back(qpc.pop_front());
          void'(qins.pop_front());
        end
        if (ms == M_RUN) begin
          if (mpc >= prog_end) ms = M_DRAIN;
          else if (n < DEPTH || pop) begin
            qpc.push_back(mpc);
            qins.push_back(int'(rom[mpc]));
            mpc = (mpc + 1) % 4096;
          end
        end else if (qpc.size() == 0) ms = M_DONE;
      end
    end
  end
  always @(negedge clk) begin
    chk("rom_addr", 32'(rom_addr), 32'(mpc));
    chk("instr_valid", 32'(valid), 32'(qpc.size() > 0));
    chk("instr", 32'(instr), qpc.size() > 0 ? 32'(qins[0]) : 32'd0);
    chk("instr_pc", 32'(instr_pc), qpc.size() > 0 ? 32'(qpc[0]) : 32'd0);
    chk("busy", 32'(busy), 32'(ms == M_RUN || ms == M_DRAIN));
    chk("done", 32'(done), 32'(ms == M_DONE));
  end
  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 9'(i * 37 + 5);
    rom[0] = 9'h101;
    rom[1] = 9'h002;
    rom[2] = 9'h1FF;
    step(2);
    rst_n = 1;
    chk("reset_rom_addr", 32'(rom_addr), 0);
    chk("reset_valid", 32'(valid), 0);
    chk("reset_busy_done", {busy, done}, 0);
    // basic program: 3 words then end marker
    ready = 1;
    req = 1;
    step();
    req = 0;
    chk("t1_not_yet_valid", 32'(valid), 0);
    step();
    chk("t1_first_valid", 32'(valid), 1);
    chk("t1_first_instr", 32'(instr), 32'h101);
    chk("t1_first_pc", 32'(instr_pc), 0);
    step(4);
    chk("t1_done", 32'(done), 1);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_pop_count", popped.size(), 3);
    for (int i = 0; i < 3; i++) chk("t1_pop_seq", popped[i], i);
    // backpressure: queue saturates, fetch_pc stalls at 4
    popped.delete();
    prog_end = 64;
    ready = 0;
    req = 1;
    step();
    req = 0;
    step(10);
    chk("t2_stall_addr", 32'(rom_addr), 4);
    chk("t2_stall_head", 32'(instr_pc), 0);
    ready = 1;
    step(5);
    chk("t2_head_after", 32'(instr_pc), 5);
    chk("t2_addr_after", 32'(rom_addr), 9);
    chk("t2_pop_count", popped.size(), 5);
    for (int i = 0; i < popped.size(); i++) chk("t2_pop_seq", popped[i], i);
    // jump while queue holds 5..8
    jump_en = 1;
    jump_target = 12'h020;
    step();
    jump_en = 0;
    chk("t3_bubble", 32'(valid), 0);
    chk("t3_addr", 32'(rom_addr), 32'h020);
    step();
    chk("t3_target_valid", 32'(valid), 1);
    chk("t3_target_pc", 32'(instr_pc), 32'h020);
    step(4);
    chk("t3_first_after_jump", popped[5], 32'h020);
    for (int i = 0; i < popped.size(); i++)
      chk("t3_no_stale", 32'(popped[i] >= 6 && popped[i] <= 8), 0);
    // jump and rom_end on the same edge
    prog_end = 0;
    jump_en = 1;
    jump_target = 12'h040;
    step();
    jump_en = 0;
    prog_end = 12'h042;
    chk("t4_jump_over_end_addr", 32'(rom_addr), 32'h040);
    chk("t4_jump_over_end_busy", {busy, done}, 2);
    ready = 0;
    step(3);
    chk("t4_drain_busy", 32'(busy), 1);
    chk("t4_drain_valid", 32'(valid), 1);
    jump_en = 1;
    jump_target = 12'h050;
    prog_end = 12'h052;
    step();
    jump_en = 0;
    chk("t4_drain_jump_addr", 32'(rom_addr), 32'h050);
    chk("t4_drain_jump_valid", 32'(valid), 0);
    ready = 1;
    step(8);
    chk("t4_done", 32'(done), 1);
    jump_en = 1;
    jump_target = 12'h077;
    step();
    jump_en = 0;
    chk("t4_done_jump_ignored", 32'(done), 1);
    chk("t4_done_addr_held", 32'(rom_addr), 32'h052);
    // wrap 0xFFF -> 0x000
    prog_end = 8192;
    req = 1;
    step();
    req = 0;
    jump_en = 1;
    jump_target = 12'hFFE;
    step();
    jump_en = 0;
    popped.delete();
    step(5);
    chk("t5_wrap0", popped[0], 32'hFFE);
    chk("t5_wrap1", popped[1], 32'hFFF);
    chk("t5_wrap2", popped[2], 32'h000);
    // async reset with 3 entries queued
    ready = 0;
    jump_en = 1;
    jump_target = 12'h100;
    step();
    jump_en = 0;
    step(3);
    chk("t6_pre_reset_pc", 32'(instr_pc), 32'h100);
    #2;
    rst_n = 0;
    #1;
    chk("t6_async_addr", 32'(rom_addr), 0);
    chk("t6_async_valid", 32'(valid), 0);
    chk("t6_async_instr", {instr, instr_pc}, 0);
    chk("t6_async_busy_done", {busy, done}, 0);
    step();
    rst_n = 1;
    // restart, with req pulses during RUN that must not disturb the PC stream
    ready = 1;
    req = 1;
    step();
    req = 0;
    popped.delete();
    step(3);
    req = 1;
    step(2);
    req = 0;
    step(3);
    chk("t6_restart_pops", popped.size(), 7);
    for (int i = 0; i < popped.size(); i++) chk("t6_restart_seq", popped[i], i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
